crypt_stream: RTL

CRYPT_STREAM -- requirements
Module: crypt_stream

---
 rtl/crypt_stream.sv | 63 ++++++
 1 files changed

// File: rtl/crypt_stream.sv
// rtl/crypt_stream.sv - XOR stream cipher with a static key or a rolling Galois LFSR keystream
// One-word output register with a valid/ready handshake on both sides.
module crypt_stream #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = 32'h80200003,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count
);

  logic [WIDTH-1:0] key_reg;
  logic [WIDTH-1:0] ks_reg;
  logic [WIDTH-1:0] ks_next;
  logic             accept;
  logic             drain;

  // A key load blocks acceptance so the new key never mixes with an in-flight word.
  assign in_ready = !key_load && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign ks_next  = (ks_reg >> 1) ^ (ks_reg[0] ? TAPS : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg    <= '0;
      ks_reg     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
    end else begin
      if (key_load) begin
        key_reg    <= key_in;
        ks_reg     <= key_in;
        word_count <= '0;
      end else if (accept) begin
        word_count <= word_count + CNT_W'(1);
        if (mode) begin
          ks_reg <= ks_next;
        end
      end

      // Accept and drain in the same cycle keeps out_valid high with the new word.
      if (accept) begin
        out_data  <= in_data ^ (mode ? ks_reg : key_reg);
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
